sync_fifo_fwft: RTL and testbench
=================================

Name: sync_fifo_fwft

Overview:
- Parametrised single-clock FIFO with valid/ready on both sides.
- First-word-fall-through read: the head entry is visible on out_data while out_valid=1.
- Generalises the fixed 8x16 wr_en/rd_en FIFO with:
  - occupancy count;
  - programmable almost-full and almost-empty flags;
  - synchronous flush;
  - optional zero-latency bypass.
- Sits between the GPIO/PS2 input path and the consumers in top.

Parameters:
- DATA_WIDTH, 8: payload width in bits.
- DATA_DEPTH, 16: number of entries; power of two, >= 2.
- ADDR_WIDTH, $clog2(DATA_DEPTH): index width; derived, never overridden.
- AFULL_THRESH, DATA_DEPTH-2: almost_full asserts when level >= this.
- AEMPTY_THRESH, 1: almost_empty asserts when level <= this.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous clear of contents.
- in_valid  in  1  write request.
- in_ready  out  1  FIFO can accept data.
- in_data  in  DATA_WIDTH  write payload.
- out_valid  out  1  head entry available.
- out_ready  in  1  consumer takes the head entry.
- out_data  out  DATA_WIDTH  head payload.
- level  out  ADDR_WIDTH+1  current occupancy, 0..DATA_DEPTH.
- almost_full  out  1  level >= AFULL_THRESH.
- almost_empty  out  1  level <= AEMPTY_THRESH.

Behaviour:
- Reset values (async rst=1):
  - wr_ptr = rd_ptr = 0, level = 0.
  - out_valid = 0, in_ready = 1, out_data = 0.
  - almost_empty = 1, almost_full = 0.
  - Storage array is not reset.
- Pointers are ADDR_WIDTH+1 bits; the MSB is the wrap bit.
  - empty: pointers equal.
  - full: index bits equal and wrap bits differ.
  - Index wraps from DATA_DEPTH-1 to 0 with the wrap bit toggled.
- Handshakes:
  - in_ready = !full.
  - out_valid = !empty.
  - push = in_valid & in_ready; pop = out_valid & out_ready.
  - in_ready and out_valid are combinational from registered state only; no dependence on in_valid or out_ready.
- Push: mem[wr_ptr] <= in_data, wr_ptr+1.
- Pop: rd_ptr+1.
- level update:
  - +1 on push only.
  - -1 on pop only.
  - Unchanged on simultaneous push and pop.
- Latency:
  - Write to out_valid: 1 cycle (data visible the cycle after the push edge).
  - Pop to next head: same cycle after the edge.
- out_data = mem[rd_ptr[ADDR_WIDTH-1:0]] when !empty, else 0 (asynchronous read).
- Full with out_ready=1: the pop happens but no push that cycle, because in_ready was 0. in_ready rises next cycle.
- Empty with out_ready=1: no pop. level never underflows or overflows.
- flush=1:
  - Next edge sets wr_ptr = rd_ptr = 0 and level = 0.
  - flush has priority over push/pop in the same cycle; data written that cycle is discarded.
- Reset asserted mid-transfer: the state is lost immediately (async). No handshake completes on the reset edge.
- almost_full / almost_empty are compares of registered level; they are glitch-free relative to clk.

Optional Feature:
- Macro FIFO_BYPASS_EN.
- Defined: when empty and in_valid=1:
  - out_valid = 1 and out_data = in_data, combinationally.
  - If out_ready=1 in that cycle, the word passes through without touching memory; pointers and level are unchanged.
  - If out_ready=0, a normal push occurs.
  - in_ready stays !full.
- Undefined: there is no combinational in-to-out path, and out_valid is 0 whenever the FIFO is empty.

Decomposition:
- Package fifo_pkg:
  - localparam helpers: function ptr_width(depth) and function is_pow2(depth), used in an elaboration-time assertion that DATA_DEPTH is a power of two.
  - Default width/depth constants.
- One sub-module, fifo_mem:
  - DATA_WIDTH x DATA_DEPTH register array.
  - Synchronous write port (we, waddr, wdata).
  - Asynchronous read port (raddr, rdata).
  - No reset.

Test Plan (WIDTH=8, DEPTH=16, AFULL=14, AEMPTY=1):
- Reset, then 16 pushes 0x00..0x0F with out_ready=0:
  - level = 16, in_ready = 0, almost_full = 1 from level 14.
  - 17th in_valid is ignored.
- Full, then out_ready=1 for 16 cycles, in_valid=0:
  - out_data sequence is 0x00..0x0F, then out_valid = 0 and level = 0.
- Continuous push+pop for 40 cycles at level 5:
  - level stays 5 through pointer wrap; data order preserved.
- Push 0xA5, 0x5A, then flush with in_valid=1 and in_data=0x77:
  - Next cycle level = 0, out_valid = 0.
  - 0x77 is not stored.
- Push 3 words, then assert rst asynchronously mid-cycle:
  - out_valid drops immediately, level = 0, in_ready = 1.
- FIFO_BYPASS_EN defined, empty, in_valid=1, in_data=0x3C, out_ready=1:
  - out_valid = 1 and out_data = 0x3C in the same cycle.
  - level stays 0.
  - Without the macro: out_valid = 0 that cycle, then 0x3C appears next cycle.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared constants and elaboration helpers for the first-word-fall-through FIFO.
// Optional combinational bypass is controlled by FIFO_BYPASS_EN (see sync_fifo_fwft).
package fifo_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_DATA_DEPTH = 16;

    // Pointer width: index bits plus one wrap bit.
    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    // True when depth is a power of two and at least 2.
    function automatic bit is_pow2(input int depth);
        return (depth >= 2) && ((depth & (depth - 1)) == 0);
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// Register-array storage: synchronous write, asynchronous read.
// Contents are not reset; validity is tracked by the pointers.
module fifo_mem
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DATA_DEPTH = DEF_DATA_DEPTH,
    parameter int ADDR_WIDTH = $clog2(DATA_DEPTH)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] r_mem [DATA_DEPTH];

    // Write port: store one word on the rising edge when enabled.
    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata = r_mem[raddr];

endmodule

// File: rtl/sync_fifo_fwft.sv
// Single-clock FWFT FIFO with valid/ready, level count and almost flags.
// Define FIFO_BYPASS_EN for a zero-latency in-to-out path when empty.
module sync_fifo_fwft
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
    parameter int DATA_DEPTH    = DEF_DATA_DEPTH,
    localparam int ADDR_WIDTH   = $clog2(DATA_DEPTH),
    parameter int AFULL_THRESH  = DATA_DEPTH - 2,
    parameter int AEMPTY_THRESH = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [ADDR_WIDTH:0]   level,
    output logic                  almost_full,
    output logic                  almost_empty
);

    localparam int PW = ptr_width(DATA_DEPTH);

    localparam logic [PW-1:0]     PTR_ONE = PW'(1);
    localparam logic [ADDR_WIDTH:0] LVL_ONE = (ADDR_WIDTH + 1)'(1);
    localparam logic [ADDR_WIDTH:0] AF_LVL  = (ADDR_WIDTH + 1)'(AFULL_THRESH);
    localparam logic [ADDR_WIDTH:0] AE_LVL  = (ADDR_WIDTH + 1)'(AEMPTY_THRESH);

    if (!is_pow2(DATA_DEPTH)) begin : g_depth_chk
        $error("sync_fifo_fwft: DATA_DEPTH must be a power of two >= 2");
    end

    logic [PW-1:0]         r_wr_ptr;
    logic [PW-1:0]         r_rd_ptr;
    logic [ADDR_WIDTH:0]   r_level;

    logic                  w_empty;
    logic                  w_full;
    logic                  w_bypass;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_we;
    logic [DATA_WIDTH-1:0] w_rdata;

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[ADDR_WIDTH-1:0] == r_rd_ptr[ADDR_WIDTH-1:0])
                   && (r_wr_ptr[ADDR_WIDTH] != r_rd_ptr[ADDR_WIDTH]);

`ifdef FIFO_BYPASS_EN
    assign w_bypass = w_empty & in_valid;
`else
    assign w_bypass = 1'b0;
`endif

    // A bypassed word taken in the same cycle never enters storage.
    assign w_push = in_valid & ~w_full & ~(w_bypass & out_ready);
    assign w_pop  = ~w_empty & out_ready;
    assign w_we   = w_push & ~flush;

    assign in_ready     = ~w_full;
    assign out_valid    = ~w_empty | w_bypass;
    assign level        = r_level;
    assign almost_full  = (r_level >= AF_LVL);
    assign almost_empty = (r_level <= AE_LVL);

    // Head data: stored entry, else bypassed input, else zero.
    always_comb begin
        out_data = '0;
        if (!w_empty) begin
            out_data = w_rdata;
        end else if (w_bypass) begin
            out_data = in_data;
        end
    end

    // Pointer and occupancy state; flush overrides any push/pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LVL_ONE;
                2'b01:   r_level <= r_level - LVL_ONE;
                default: r_level <= r_level;
            endcase
        end
    end

    fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DATA_DEPTH (DATA_DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_mem (
        .clk   (clk),
        .we    (w_we),
        .waddr (r_wr_ptr[ADDR_WIDTH-1:0]),
        .wdata (in_data),
        .raddr (r_rd_ptr[ADDR_WIDTH-1:0]),
        .rdata (w_rdata)
    );

endmodule

// File: tb/tb_sync_fifo_fwft.sv
// Directed self-checking bench for sync_fifo_fwft (8x16, AF=14, AE=1).
// Bypass expectations follow FIFO_BYPASS_EN when it is defined.
module tb_sync_fifo_fwft;

    logic       clk;
    logic       rst;
    logic       flush;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic [4:0] level;
    logic       almost_full;
    logic       almost_empty;

    int n_pass  = 0;
    int n_total = 0;

    sync_fifo_fwft #(
        .DATA_WIDTH    (8),
        .DATA_DEPTH    (16),
        .AFULL_THRESH  (14),
        .AEMPTY_THRESH (1)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .level        (level),
        .almost_full  (almost_full),
        .almost_empty (almost_empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge; inputs are then driven at edge+1, checks at edge+2.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0;
        in_data = 8'h00; out_ready = 1'b0;
        step(); step();
        rst = 1'b0;
        #1;
        n_total++;
        if (out_valid !== 1'b0) $display("FAIL rst_out_valid got %b want 0", out_valid);
        else n_pass++;
        n_total++;
        if (in_ready !== 1'b1) $display("FAIL rst_in_ready got %b want 1", in_ready);
        else n_pass++;
        n_total++;
        if (level !== 5'd0) $display("FAIL rst_level got %0d want 0", level);
        else n_pass++;
        n_total++;
        if (out_data !== 8'h00) $display("FAIL rst_out_data got %h want 00", out_data);
        else n_pass++;
        n_total++;
        if (almost_empty !== 1'b1 || almost_full !== 1'b0)
            $display("FAIL rst_flags got ae=%b af=%b want ae=1 af=0", almost_empty, almost_full);
        else n_pass++;
    endtask

    task automatic test_fill();
        for (int i = 0; i < 16; i++) begin
            in_valid = 1'b1; in_data = 8'(i); out_ready = 1'b0;
            step();
            #1;
            n_total++;
            if (level !== 5'(i + 1)) $display("FAIL fill_level[%0d] got %0d want %0d", i, level, i + 1);
            else n_pass++;
            n_total++;
            if (almost_full !== (i + 1 >= 14))
                $display("FAIL fill_afull[%0d] got %b want %b", i, almost_full, (i + 1 >= 14));
            else n_pass++;
            n_total++;
            if (in_ready !== (i + 1 < 16))
                $display("FAIL fill_in_ready[%0d] got %b want %b", i, in_ready, (i + 1 < 16));
            else n_pass++;
            n_total++;
            if (out_valid !== 1'b1 || out_data !== 8'h00)
                $display("FAIL fill_head[%0d] got v=%b d=%h want v=1 d=00", i, out_valid, out_data);
            else n_pass++;
        end
        in_valid = 1'b1; in_data = 8'hEE;
        step();
        in_valid = 1'b0;
        #1;
        n_total++;
        if (level !== 5'd16) $display("FAIL fill_overflow_level got %0d want 16", level);
        else n_pass++;
    endtask

    task automatic test_drain();
        in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            #1;
            n_total++;
            if (out_valid !== 1'b1 || out_data !== 8'(i))
                $display("FAIL drain_data[%0d] got v=%b d=%h want v=1 d=%h", i, out_valid, out_data, 8'(i));
            else n_pass++;
            n_total++;
            if (almost_empty !== (16 - i <= 1))
                $display("FAIL drain_aempty[%0d] got %b want %b", i, almost_empty, (16 - i <= 1));
            else n_pass++;
            step();
        end
        out_ready = 1'b0;
        #1;
        n_total++;
        if (out_valid !== 1'b0 || level !== 5'd0 || out_data !== 8'h00)
            $display("FAIL drain_empty got v=%b lvl=%0d d=%h want v=0 lvl=0 d=00", out_valid, level, out_data);
        else n_pass++;
    endtask

    task automatic test_stream();
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_data = 8'h40 + 8'(i); out_ready = 1'b0;
            step();
        end
        for (int k = 0; k < 40; k++) begin
            in_valid = 1'b1; in_data = 8'h45 + 8'(k); out_ready = 1'b1;
            #1;
            n_total++;
            if (out_data !== 8'h40 + 8'(k))
                $display("FAIL stream_data[%0d] got %h want %h", k, out_data, 8'h40 + 8'(k));
            else n_pass++;
            step();
            n_total++;
            if (level !== 5'd5) $display("FAIL stream_level[%0d] got %0d want 5", k, level);
            else n_pass++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        for (int j = 0; j < 5; j++) begin
            #1;
            n_total++;
            if (out_data !== 8'h68 + 8'(j))
                $display("FAIL stream_tail[%0d] got %h want %h", j, out_data, 8'h68 + 8'(j));
            else n_pass++;
            step();
        end
        out_ready = 1'b0;
        #1;
        n_total++;
        if (level !== 5'd0 || out_valid !== 1'b0)
            $display("FAIL stream_end got lvl=%0d v=%b want lvl=0 v=0", level, out_valid);
        else n_pass++;
    endtask

    task automatic test_flush();
        in_valid = 1'b1; out_ready = 1'b0; in_data = 8'hA5;
        step();
        in_data = 8'h5A;
        step();
        #1;
        n_total++;
        if (level !== 5'd2) $display("FAIL flush_pre_level got %0d want 2", level);
        else n_pass++;
        flush = 1'b1; in_valid = 1'b1; in_data = 8'h77;
        step();
        flush = 1'b0; in_valid = 1'b0;
        #1;
        n_total++;
        if (level !== 5'd0 || out_valid !== 1'b0 || out_data !== 8'h00)
            $display("FAIL flush_clear got lvl=%0d v=%b d=%h want lvl=0 v=0 d=00", level, out_valid, out_data);
        else n_pass++;
        in_valid = 1'b1; in_data = 8'h11;
        step();
        in_valid = 1'b0;
        #1;
        n_total++;
        if (level !== 5'd1 || out_data !== 8'h11)
            $display("FAIL flush_after got lvl=%0d d=%h want lvl=1 d=11", level, out_data);
        else n_pass++;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_data = 8'hC0 + 8'(i); out_ready = 1'b0;
            step();
        end
        in_valid = 1'b0;
        #1;
        n_total++;
        if (level !== 5'd3) $display("FAIL arst_pre_level got %0d want 3", level);
        else n_pass++;
        rst = 1'b1;
        #1;
        n_total++;
        if (out_valid !== 1'b0 || level !== 5'd0 || in_ready !== 1'b1)
            $display("FAIL arst_immediate got v=%b lvl=%0d rdy=%b want v=0 lvl=0 rdy=1", out_valid, level, in_ready);
        else n_pass++;
        in_valid = 1'b1; in_data = 8'h99;
        step();
        in_valid = 1'b0;
        rst = 1'b0;
        #1;
        n_total++;
        if (level !== 5'd0 || out_valid !== 1'b0)
            $display("FAIL arst_hold got lvl=%0d v=%b want lvl=0 v=0", level, out_valid);
        else n_pass++;
    endtask

    task automatic test_bypass();
        in_valid = 1'b1; in_data = 8'h3C; out_ready = 1'b1;
        #1;
`ifdef FIFO_BYPASS_EN
        n_total++;
        if (out_valid !== 1'b1 || out_data !== 8'h3C)
            $display("FAIL bypass_same got v=%b d=%h want v=1 d=3c", out_valid, out_data);
        else n_pass++;
        step();
        in_valid = 1'b0; out_ready = 1'b0;
        #1;
        n_total++;
        if (level !== 5'd0 || out_valid !== 1'b0)
            $display("FAIL bypass_after got lvl=%0d v=%b want lvl=0 v=0", level, out_valid);
        else n_pass++;
`else
        n_total++;
        if (out_valid !== 1'b0 || out_data !== 8'h00)
            $display("FAIL nobypass_same got v=%b d=%h want v=0 d=00", out_valid, out_data);
        else n_pass++;
        step();
        in_valid = 1'b0; out_ready = 1'b0;
        #1;
        n_total++;
        if (out_valid !== 1'b1 || out_data !== 8'h3C || level !== 5'd1)
            $display("FAIL nobypass_next got v=%b d=%h lvl=%0d want v=1 d=3c lvl=1", out_valid, out_data, level);
        else n_pass++;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        #1;
        n_total++;
        if (level !== 5'd0) $display("FAIL nobypass_drain got %0d want 0", level);
        else n_pass++;
`endif
    endtask

    initial begin
        test_reset();
        test_fill();
        test_drain();
        test_stream();
        test_flush();
        test_async_reset();
        test_bypass();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
